// File: rtl/ntt16_seq_ctrl.sv
// Sequencer for a 16-point CT-butterfly NTT network: load, wait for the pipeline, capture, drain.
// Optional macro NTT16_BITREV_OUT_EN selects bit-reversed drain order.
module ntt16_seq_ctrl #(
  parameter int DW     = 16,
  parameter int N      = 16,
  parameter int BU_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [DW-1:0]    cfg_data,
  output logic [N*DW-1:0]  bu_a,
  output logic [15*DW-1:0] bu_shi,
  input  logic [N*DW-1:0]  bu_ct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [3:0]       out_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [3:0] LAT_C  = 4'(BU_LAT);
  localparam logic [3:0] LAST_C = 4'd15;

  state_t        state_q, state_d;
  logic [3:0]    ld_cnt_q, ld_cnt_d;
  logic [3:0]    wt_cnt_q, wt_cnt_d;
  logic [3:0]    dr_cnt_q, dr_cnt_d;
  logic [DW-1:0] coef_q [N];
  logic [DW-1:0] coef_d [N];
  logic [DW-1:0] res_q  [N];
  logic [DW-1:0] res_d  [N];
  logic [DW-1:0] tw_q   [15];
  logic [DW-1:0] tw_d   [15];
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [3:0]    out_idx_q, out_idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          in_ready_q, in_ready_d;
  logic          in_acc_s, out_acc_s;
  logic [3:0]    nxt_idx_s;

  function automatic logic [3:0] drain_order(input logic [3:0] i);
`ifdef NTT16_BITREV_OUT_EN
    return {i[0], i[1], i[2], i[3]};
`else
    return i;
`endif
  endfunction

  assign in_acc_s  = in_valid & in_ready_q;
  assign out_acc_s = out_valid_q & out_ready;
  assign nxt_idx_s = drain_order(dr_cnt_q + 4'd1);

  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    wt_cnt_d    = wt_cnt_q;
    dr_cnt_d    = dr_cnt_q;
    coef_d      = coef_q;
    res_d       = res_q;
    tw_d        = tw_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Table writes are only legal here; index 0 has no twiddle slot.
        if (cfg_we && (cfg_addr != 4'd0)) begin
          tw_d[cfg_addr - 4'd1] = cfg_data;
        end else begin
          tw_d = tw_q;
        end
        if (in_acc_s) begin
          coef_d[0] = in_data;
          ld_cnt_d  = 4'd1;
          state_d   = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (in_acc_s) begin
          coef_d[ld_cnt_q] = in_data;
          if (ld_cnt_q == LAST_C) begin
            ld_cnt_d = 4'd0;
            wt_cnt_d = 4'd0;
            state_d  = S_WAIT;
          end else begin
            ld_cnt_d = ld_cnt_q + 4'd1;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_WAIT: begin
        if (wt_cnt_q == LAT_C) begin
          for (int k = 0; k < N; k++) begin
            res_d[k] = bu_ct[DW*k +: DW];
          end
          dr_cnt_d    = 4'd0;
          out_valid_d = 1'b1;
          out_idx_d   = drain_order(4'd0);
          out_data_d  = bu_ct[DW*int'(drain_order(4'd0)) +: DW];
          state_d     = S_DRAIN;
        end else begin
          wt_cnt_d = wt_cnt_q + 4'd1;
        end
      end
      S_DRAIN: begin
        if (out_acc_s) begin
          if (dr_cnt_q == LAST_C) begin
            dr_cnt_d    = 4'd0;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end else begin
            dr_cnt_d   = dr_cnt_q + 4'd1;
            out_idx_d  = nxt_idx_s;
            out_data_d = res_q[nxt_idx_s];
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d     = (state_d != S_IDLE);
    in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ld_cnt_q    <= 4'd0;
      wt_cnt_q    <= 4'd0;
      dr_cnt_q    <= 4'd0;
      for (int k = 0; k < N; k++) begin
        coef_q[k] <= '0;
        res_q[k]  <= '0;
      end
      for (int j = 0; j < 15; j++) begin
        tw_q[j] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      wt_cnt_q    <= wt_cnt_d;
      dr_cnt_q    <= dr_cnt_d;
      coef_q      <= coef_d;
      res_q       <= res_d;
      tw_q        <= tw_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_bu_a
    assign bu_a[DW*g +: DW] = coef_q[g];
  end
  for (genvar g = 0; g < 15; g++) begin : g_bu_shi
    assign bu_shi[DW*g +: DW] = tw_q[g];
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ntt16_seq_ctrl.sv
// Directed, table-driven bench for ntt16_seq_ctrl; the network is modelled by bench-driven bu_ct.
module tb_ntt16_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  in_data = 16'h0000;
  logic         cfg_we = 1'b0;
  logic [3:0]   cfg_addr = 4'd0;
  logic [15:0]  cfg_data = 16'h0000;
  logic [255:0] bu_a;
  logic [239:0] bu_shi;
  logic [255:0] bu_ct = 256'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [15:0]  out_data;
  logic [3:0]   out_idx;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;
  int order_tab [16];
  logic [15:0] tw_model [15];

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] data;
    int          chk_slot;
    logic [15:0] chk_val;
  } cfg_vec_t;
  cfg_vec_t vecs [17];

  ntt16_seq_ctrl #(.DW(16), .N(16), .BU_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .bu_a(bu_a), .bu_shi(bu_shi), .bu_ct(bu_ct),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] shi_model();
    logic [255:0] v = '0;
    for (int j = 0; j < 15; j++) v[16*j +: 16] = tw_model[j];
    return v;
  endfunction

  function automatic logic [255:0] ct_pattern(input logic [15:0] base);
    logic [255:0] v;
    for (int k = 0; k < 16; k++) v[16*k +: 16] = base + 16'(k);
    return v;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " in_ready"},  {255'd0, in_ready},  256'd1);
    chk({tag, " busy"},      {255'd0, busy},      256'd0);
    chk({tag, " out_valid"}, {255'd0, out_valid}, 256'd0);
    chk({tag, " done"},      {255'd0, done},      256'd0);
    chk({tag, " out_data"},  {240'd0, out_data},  256'd0);
    chk({tag, " out_idx"},   {252'd0, out_idx},   256'd0);
    chk({tag, " bu_a"},      bu_a,                256'd0);
    chk({tag, " bu_shi"},    {16'd0, bu_shi},     256'd0);
  endtask

  // gap: idle cycles before each word; rmode 1 gives out_ready 1,0,0,1; abort_idx>=0 resets in DRAIN
  task automatic run_xform(input int gap, input int rmode, input logic [15:0] base,
                           input int abort_idx, input logic first_cfg);
    logic [255:0] exp_a = '0;
    int n = 0;
    int cyc = 0;
    for (int k = 0; k < 16; k++) begin
      repeat (gap) begin
        @(negedge clk);
        in_valid = 1'b0; cfg_we = 1'b0;
        chk("load_gap_ready", {255'd0, in_ready}, 256'd1);
      end
      @(negedge clk);
      in_valid = 1'b1; in_data = base + 16'(k); cfg_we = 1'b0;
      exp_a[16*k +: 16] = base + 16'(k);
      if (k == 0 && first_cfg) begin
        cfg_we = 1'b1; cfg_addr = 4'd5; cfg_data = 16'h1234; tw_model[4] = 16'h1234;
      end
      if (k == 4) begin
        cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 16'hBEEF;
      end
      chk("load_ready", {255'd0, in_ready}, 256'd1);
      chk("load_busy", {255'd0, busy}, {255'd0, (k != 0)});
      @(posedge clk);
    end
    @(negedge clk);
    cfg_we = 1'b0; in_data = 16'h7777;
    chk("bu_a_loaded", bu_a, exp_a);
    chk("bu_shi_table", {16'd0, bu_shi}, shi_model());
    // network model: correct results only on the cycle before the expected capture edge
    for (int s = 0; s <= 4; s++) begin
      bu_ct = (s == 4) ? ct_pattern(16'hA000) : ct_pattern(16'h5000 + 16'(s * 16));
      chk("wait_ready_low", {255'd0, in_ready}, 256'd0);
      chk("wait_no_valid", {255'd0, out_valid}, 256'd0);
      chk("wait_busy", {255'd0, busy}, 256'd1);
      @(posedge clk);
      @(negedge clk);
    end
    bu_ct = ct_pattern(16'h5900);
    in_valid = 1'b0;
    chk("capture_timing_valid", {255'd0, out_valid}, 256'd1);
    chk("bu_a_after_17th", bu_a, exp_a);
    while (n < 16 && cyc < 200) begin
      chk("drain_valid", {255'd0, out_valid}, 256'd1);
      chk("drain_idx", {252'd0, out_idx}, 256'(order_tab[n]));
      chk("drain_data", {240'd0, out_data}, 256'(16'hA000 + 16'(order_tab[n])));
      chk("drain_ready_low", {255'd0, in_ready}, 256'd0);
      chk("drain_no_done", {255'd0, done}, 256'd0);
      if (abort_idx >= 0 && order_tab[n] == abort_idx) begin
        #2 rst = 1'b0;
        for (int j = 0; j < 15; j++) tw_model[j] = 16'h0000;
        #1 chk_reset_outputs("async_rst");
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk_reset_outputs("post_rst");
        end
        return;
      end
      out_ready = (rmode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      @(posedge clk);
      if (out_ready) n++;
      @(negedge clk);
      cyc++;
    end
    chk("drain_count", 256'(n), 256'd16);
    out_ready = 1'b0;
    chk("done_pulse", {255'd0, done}, 256'd1);
    chk("done_valid_low", {255'd0, out_valid}, 256'd0);
    chk("done_busy_low", {255'd0, busy}, 256'd0);
    chk("done_ready_high", {255'd0, in_ready}, 256'd1);
    @(negedge clk);
    chk("done_one_cycle", {255'd0, done}, 256'd0);
  endtask

  initial begin
`ifdef NTT16_BITREV_OUT_EN
    order_tab = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
    for (int i = 0; i < 16; i++) order_tab[i] = i;
`endif
    for (int j = 0; j < 15; j++) tw_model[j] = 16'h0000;
    for (int i = 0; i < 15; i++) begin
      vecs[i] = '{we: 1'b1, addr: 4'(i + 1), data: 16'(17 * (i + 1)),
                  chk_slot: i, chk_val: 16'(17 * (i + 1))};
    end
    vecs[15] = '{we: 1'b1, addr: 4'd0, data: 16'hDEAD, chk_slot: 0,  chk_val: 16'h0011};
    vecs[16] = '{we: 1'b0, addr: 4'd7, data: 16'hFFFF, chk_slot: 6,  chk_val: 16'h0077};

    repeat (3) @(negedge clk);
    chk_reset_outputs("in_reset");
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk_reset_outputs("idle_hold");
    end

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      cfg_we = vecs[i].we; cfg_addr = vecs[i].addr; cfg_data = vecs[i].data;
      if (vecs[i].we && vecs[i].addr != 4'd0) tw_model[vecs[i].addr - 4'd1] = vecs[i].data;
      @(negedge clk);
      cfg_we = 1'b0;
      chk("cfg_slot", {240'd0, bu_shi[16*vecs[i].chk_slot +: 16]}, {240'd0, vecs[i].chk_val});
      chk("cfg_table", {16'd0, bu_shi}, shi_model());
    end

    run_xform(0, 0, 16'h0001, -1, 1'b0);
    run_xform(2, 1, 16'h0101, -1, 1'b0);
    run_xform(0, 1, 16'h0201, 7, 1'b0);
    run_xform(0, 1, 16'h0301, -1, 1'b1);
    chk("simul_cfg_slot", {240'd0, bu_shi[16*4 +: 16]}, 256'h1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
